// File: rtl/mc10_ram_arbiter.sv
// rtl/mc10_ram_arbiter.sv - single-port RAM arbiter, video priority; optional MC10_ARB_STARVE_GUARD_EN
module mc10_ram_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [7:0]        vid_q,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic              cpu_ack,
    output logic [7:0]        cpu_q,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    input  logic [7:0]        ram_q,
    output logic              busy
);
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_CAP, S_DONE} state_t;

    state_t state, state_nx;
    logic   owner_cpu;
    logic   is_write;
    logic   grant_vid, grant_cpu;
    logic   starved;

`ifdef MC10_ARB_STARVE_GUARD_EN
    logic [3:0] streak;

    assign starved = (streak == 4'(STARVE_LIMIT));

    // Streak counts video wins only while the CPU is actually waiting.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            streak <= 4'd0;
        end else if (grant_cpu) begin
            streak <= 4'd0;
        end else if (grant_vid) begin
            if (!cpu_req)
                streak <= 4'd0;
            else if (streak != 4'hF)
                streak <= streak + 4'd1;
        end
    end
`else
    // Without the guard the limit never fires for any legal value.
    assign starved = (STARVE_LIMIT < 1);
`endif

    always_comb begin
        state_nx  = state;
        grant_vid = 1'b0;
        grant_cpu = 1'b0;
        case (state)
            S_IDLE: begin
                if (vid_req && !(cpu_req && starved)) begin
                    grant_vid = 1'b1;
                    state_nx  = S_ACC;
                end else if (cpu_req) begin
                    grant_cpu = 1'b1;
                    state_nx  = S_ACC;
                end
            end
            S_ACC:   state_nx = S_CAP;
            S_CAP:   state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= S_IDLE;
            owner_cpu <= 1'b0;
            is_write  <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= 8'h00;
            ram_we    <= 1'b0;
            vid_ack   <= 1'b0;
            cpu_ack   <= 1'b0;
            vid_q     <= 8'h00;
            cpu_q     <= 8'h00;
        end else begin
            state   <= state_nx;
            ram_we  <= 1'b0;
            vid_ack <= 1'b0;
            cpu_ack <= 1'b0;
            if (grant_vid) begin
                ram_addr  <= vid_addr;
                owner_cpu <= 1'b0;
                is_write  <= 1'b0;
            end
            if (grant_cpu) begin
                ram_addr  <= cpu_addr;
                owner_cpu <= 1'b1;
                is_write  <= cpu_we;
                if (cpu_we) begin
                    ram_din <= cpu_din;
                    ram_we  <= 1'b1;
                end
            end
            // Direction is taken from the latched copy so a dropped req cannot change it.
            if (state == S_CAP) begin
                if (owner_cpu) begin
                    cpu_ack <= 1'b1;
                    if (!is_write)
                        cpu_q <= ram_q;
                end else begin
                    vid_ack <= 1'b1;
                    vid_q   <= ram_q;
                end
            end
        end
    end

    assign busy = (state != S_IDLE);
endmodule

// File: doc/mc10_ram_arbiter.md
# mc10_ram_arbiter

Time-shares one single-port synchronous RAM (the 4K video/work RAM) between the CPU bus and the MC6847 video fetch path, replacing the dual-port RAM arrangement. Both requesters use a level req / single-cycle ack handshake. Video has fixed priority, with an optional starvation guard that guarantees CPU progress. Sits in the `clk_sys` domain between the CPU data-bus mux, the VDG address generator and the RAM macro.

## Interface
Parameters:
- `ADDR_W`, 12, RAM address width (4K words).
- `STARVE_LIMIT`, 3, consecutive video grants tolerated while CPU waits (guard build only); range 1..15.

Ports:
- `clk_sys` in 1: sole clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `vid_req` in 1: video read request, level, held until `vid_ack`.
- `vid_addr` in ADDR_W: video read address, stable while `vid_req`.
- `vid_ack` out 1: one-cycle pulse, `vid_q` valid.
- `vid_q` out 8: last video read data, held until next `vid_ack`.
- `cpu_req` in 1: CPU request, level, held until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read; stable while `cpu_req`.
- `cpu_addr` in ADDR_W: CPU address.
- `cpu_din` in 8: CPU write data.
- `cpu_ack` out 1: one-cycle pulse on read or write completion.
- `cpu_q` out 8: last CPU read data, unchanged by CPU writes.
- `ram_addr` out ADDR_W: registered RAM address.
- `ram_din` out 8: registered RAM write data.
- `ram_we` out 1: registered RAM write enable.
- `ram_q` in 8: RAM read data, valid one clock after the address edge.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE → ACC → CAP → DONE → IDLE. This sequence is fixed and has no shortcuts.
- Requests are sampled only in IDLE:
  - Only `vid_req` high: grant video.
  - Only `cpu_req` high: grant CPU.
  - Both high: grant video, except when the guard overrides (see Configuration).
  - Neither high: stay in IDLE.
- On the grant edge:
  - Load `ram_addr` from the winner's address.
  - For a CPU write, load `ram_din` from `cpu_din` and set `ram_we` = 1.
  - Latch the owner in a 1-bit register. Go to ACC.
- ACC: the RAM sees the address and write enable. On exit, `ram_we` returns to 0, so it is high for exactly one cycle. Go to CAP.
- CAP: `ram_q` is valid. On exit, a read latches `ram_q` into the owner's `*_q` register. The owner's ack register is set. Go to DONE.
- DONE: the owner's ack is high for this one cycle. The requester must drop or change req on the edge that ends DONE. The arbiter returns to IDLE and samples again on the next edge.
- A req dropped mid-transaction does not abort it. The access completes and the ack still pulses.
- A started write always commits.
- `ram_din` holds its last value outside writes; `ram_addr` holds the last granted address.

## Timing
- Reset values: state IDLE, `ram_we` 0, `ram_addr` 0, `ram_din` 0, `vid_ack`/`cpu_ack` 0, `vid_q`/`cpu_q` 0x00, `busy` 0, streak counter 0.
- Reset mid-transaction:
  - Next edge forces all reset values.
  - An in-flight write whose `ram_we` is already high completes its single cycle.
  - No ack is issued for the aborted transaction.
- Latency: a req sampled high at IDLE edge N gives `ram_we`/address at N, `ram_q` captured at N+2, and ack high in the cycle following edge N+2 (DONE).
- Throughput: one access per 4 clocks. At 4 clocks per access the arbiter must be clocked fast enough to cover one VDG fetch plus one CPU access per CPU E cycle.
- Simultaneous request from the same owner on consecutive transactions is allowed. The earliest re-grant is the edge ending DONE+1.
- Acks never overlap. Exactly one ack pulse is issued per grant.

## Configuration
- `MC10_ARB_STARVE_GUARD_EN` defined:
  - A 4-bit streak counter increments on each video grant taken while `cpu_req` is high.
  - When the counter equals `STARVE_LIMIT` and both requests are high in IDLE, the CPU is granted instead.
  - The counter clears on any CPU grant, and on any video grant taken while `cpu_req` is low.
- Not defined: strict video priority. The counter is removed, and the CPU can wait indefinitely under continuous `vid_req`.

## Test plan
- Reset, then CPU write 0xA5 to 0x123 followed by a CPU read of 0x123:
  - Expect `ram_we` high exactly one cycle.
  - Expect `cpu_ack` 3 edges after each sample.
  - Expect `cpu_q` = 0xA5.
  - Expect `busy` high for 3 cycles per access.
- `vid_req` and `cpu_req` asserted in the same IDLE cycle, guard build, `STARVE_LIMIT`=3 with `vid_req` held continuously: grants must be V,V,V,C,V,V,V,C. Non-guard build: no `cpu_ack` within 64 cycles.
- Video read 0x0FF, then CPU write to 0x0FF, then video read 0x0FF: `vid_q` returns the old value, then the new value. `cpu_q` is unchanged by the write.
- `cpu_req` dropped during ACC of a write of 0x3C to 0x010: the write commits, `cpu_ack` still pulses once, and a later read returns 0x3C.
- `reset` asserted in CAP of a video read: next cycle shows IDLE, no `vid_ack`, `vid_q` = 0x00, and outputs at reset values.
- Back-to-back video reads of 0x000..0x00F with req re-asserted right after each ack: 16 acks, one every 4 cycles, with the data matching preloaded RAM.
